// File: rtl/z80_bus_pkg.sv
// Shared bus definitions for the Z80 memory responder: state encoding,
// bus widths, default memory map constants and the ROM window test.
package z80_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ROM_LO_DEF    = 16'h0000;
  localparam logic [ADDR_W-1:0] ROM_HI_DEF    = 16'h3FFF;
  localparam logic [ADDR_W-1:0] LOAD_BASE_DEF = 16'h0000;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  // True when addr lies inside the inclusive window [lo, hi].
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/z80_spram.sv
// Single-port synchronous RAM: one address shared by read and write,
// registered read data (old contents returned on a same-cycle write).
module z80_spram #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Write-enable storage with a registered read port (maps to block RAM).
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/z80_mem_responder.sv
// Responder side of the Z80 core memory bus. Loads RAM from a byte stream
// after reset, then serves core reads with one stall cycle per new address,
// and drops (and counts) core writes that fall inside the ROM window.
module z80_mem_responder
  import z80_bus_pkg::*;
#(
  parameter int              MEM_AW    = 16,
  parameter logic [15:0]     ROM_LO    = ROM_LO_DEF,
  parameter logic [15:0]     ROM_HI    = ROM_HI_DEF,
  parameter bit              LOAD_EN   = 1'b1,
  parameter logic [15:0]     LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  out,
  input  logic        we,
  output logic [7:0]  in,
  output logic        ready,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        wp_err,
  output logic [7:0]  wp_count
);

  state_t      state_reg;
  logic [15:0] ld_ptr_reg;
  logic [15:0] tag_reg;
  logic        tag_valid_reg;
  logic [7:0]  in_hold_reg;
  logic        byp_valid_reg;
  logic [7:0]  byp_data_reg;
  logic        wp_err_reg;
  logic [7:0]  wp_count_reg;

  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_q;

  logic ld_accept;
  logic wr_accept;
  logic wr_in_rom;
  logic wr_commit;

  // Handshakes are forced low while reset is held so nothing is written then.
  assign ld_ready  = (state_reg == ST_LOAD) && !reset;
  assign ready     = (state_reg == ST_RUN) && !reset && tag_valid_reg && (tag_reg == address);
  assign ld_accept = ld_valid && ld_ready;
  assign wr_accept = we && ready;
  assign wr_in_rom = in_window(address, ROM_LO, ROM_HI);
  assign wr_commit = wr_accept && !wr_in_rom;

  // A write just committed is not yet visible on the RAM read port, so the
  // bypass byte takes priority for exactly one cycle. While stalled, the
  // last presented byte is held.
  assign in       = ready ? (byp_valid_reg ? byp_data_reg : ram_q) : in_hold_reg;
  assign wp_err   = wp_err_reg;
  assign wp_count = wp_count_reg;

  // RAM port mux: loader pointer owns the port in LOAD, the core bus in RUN.
  always_comb begin
    ram_addr  = address[MEM_AW-1:0];
    ram_wdata = out;
    ram_we    = wr_commit;
    if (state_reg == ST_LOAD) begin
      ram_addr  = ld_ptr_reg[MEM_AW-1:0];
      ram_wdata = ld_data;
      ram_we    = ld_accept;
    end
  end

  z80_spram #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Load/run sequencing, loader pointer and read tag tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= LOAD_EN ? ST_LOAD : ST_RUN;
      ld_ptr_reg    <= LOAD_BASE;
      tag_reg       <= 16'h0000;
      tag_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          tag_valid_reg <= 1'b0;
          if (ld_accept) begin
            ld_ptr_reg <= ld_ptr_reg + 16'd1;
            if (ld_last) begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          tag_reg       <= address;
          tag_valid_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // Output hold, write bypass and write-protect reporting.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_hold_reg   <= 8'h00;
      byp_valid_reg <= 1'b0;
      byp_data_reg  <= 8'h00;
      wp_err_reg    <= 1'b0;
      wp_count_reg  <= 8'h00;
    end else begin
      in_hold_reg   <= in;
      byp_valid_reg <= wr_commit;
      byp_data_reg  <= out;
      wp_err_reg    <= wr_accept && wr_in_rom;
      if (wr_accept && wr_in_rom && (wp_count_reg != 8'hFF)) begin
        wp_count_reg <= wp_count_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_z80_mem_responder.sv
// Bench for z80_mem_responder: two instances (load base 0000 and FFFF),
// read expectations go through a queue checked by a separate monitor.
module tb_z80_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [15:0] address_a  [2];
  logic [7:0]  out_a      [2];
  logic        we_a       [2];
  logic        ld_valid_a [2];
  logic [7:0]  ld_data_a  [2];
  logic        ld_last_a  [2];
  logic [7:0]  in_a       [2];
  logic        ready_a    [2];
  logic        ld_ready_a [2];
  logic        wp_err_a   [2];
  logic [7:0]  wp_count_a [2];

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  z80_mem_responder #(.LOAD_BASE(16'h0000)) u0 (
    .clock(clock), .reset(reset), .address(address_a[0]), .out(out_a[0]), .we(we_a[0]),
    .in(in_a[0]), .ready(ready_a[0]), .ld_valid(ld_valid_a[0]), .ld_data(ld_data_a[0]),
    .ld_last(ld_last_a[0]), .ld_ready(ld_ready_a[0]), .wp_err(wp_err_a[0]),
    .wp_count(wp_count_a[0])
  );

  z80_mem_responder #(.LOAD_BASE(16'hFFFF)) u1 (
    .clock(clock), .reset(reset), .address(address_a[1]), .out(out_a[1]), .we(we_a[1]),
    .in(in_a[1]), .ready(ready_a[1]), .ld_valid(ld_valid_a[1]), .ld_data(ld_data_a[1]),
    .ld_last(ld_last_a[1]), .ld_ready(ld_ready_a[1]), .wp_err(wp_err_a[1]),
    .wp_count(wp_count_a[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Monitor: pops the head expectation once its instance is ready on that address.
  always @(negedge clock) begin
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q[0];
      if (ready_a[e.sel] && address_a[e.sel] == e.addr) begin
        void'(q.pop_front());
        check($sformatf("read u%0d @%h", e.sel, e.addr), {8'h00, in_a[e.sel]}, {8'h00, e.data});
      end
    end
  end

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (q.size() == 0) break;
      @(posedge clock);
    end
    if (q.size() != 0) begin
      check("read_timeout", 16'(q.size()), 16'd0);
      q.delete();
    end
  endtask

  task automatic read_exp(input int sel, input logic [15:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    address_a[sel] = a;
    q.push_back('{sel: sel, addr: a, data: d});
    drain();
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input logic last);
    bit ok;
    @(posedge clock); #1;
    ld_valid_a[sel] = 1'b1;
    ld_data_a[sel]  = d;
    ld_last_a[sel]  = last;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      check($sformatf("load_stall u%0d", sel), {15'd0, ready_a[sel]}, 16'd0);
      if (ld_ready_a[sel]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ld_ready_timeout", 16'd0, 16'd1);
    @(posedge clock); #1;
    ld_valid_a[sel] = 1'b0;
    ld_last_a[sel]  = 1'b0;
  endtask

  task automatic do_write(input int sel, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    @(posedge clock); #1;
    address_a[sel] = a;
    out_a[sel]     = d;
    we_a[sel]      = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (ready_a[sel]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("write_ready_timeout", 16'd0, 16'd1);
    @(posedge clock); #1;
    we_a[sel] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      address_a[i] = 16'h0000; out_a[i] = 8'h00; we_a[i] = 1'b0;
      ld_valid_a[i] = 1'b0; ld_data_a[i] = 8'h00; ld_last_a[i] = 1'b0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst ld_ready", {15'd0, ld_ready_a[0]}, 16'd0);
    check("rst ready", {15'd0, ready_a[0]}, 16'd0);
    check("rst in", {8'd0, in_a[0]}, 16'h0000);
    check("rst wp_err", {15'd0, wp_err_a[0]}, 16'd0);
    check("rst wp_count", {8'd0, wp_count_a[0]}, 16'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("post_rst ld_ready", {15'd0, ld_ready_a[0]}, 16'd1);
    check("post_rst ready", {15'd0, ready_a[0]}, 16'd0);

    // Partial load, then reset mid-load: pointer must restart at LOAD_BASE.
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("reload ld_ready", {15'd0, ld_ready_a[0]}, 16'd1);

    send_byte(0, 8'h3E, 1'b0);
    send_byte(0, 8'h42, 1'b0);
    send_byte(0, 8'h76, 1'b1);
    @(negedge clock);
    check("run ld_ready", {15'd0, ld_ready_a[0]}, 16'd0);
    check("run first ready", {15'd0, ready_a[0]}, 16'd0);

    // Loaded bytes; 0000 also proves the mid-load reset rewound the pointer.
    read_exp(0, 16'h0000, 8'h3E);

    // New address: one stall cycle holding the previous byte, then data.
    @(posedge clock); #1;
    address_a[0] = 16'h0001;
    q.push_back('{sel: 0, addr: 16'h0001, data: 8'h42});
    @(negedge clock);
    check("stall ready", {15'd0, ready_a[0]}, 16'd0);
    check("stall in hold", {8'd0, in_a[0]}, 16'h003E);
    drain();
    @(negedge clock);
    check("held ready", {15'd0, ready_a[0]}, 16'd1);
    read_exp(0, 16'h0001, 8'h42);
    read_exp(0, 16'h0002, 8'h76);

    // RAM write with bypass, then re-read after moving away.
    do_write(0, 16'h8000, 8'hA5);
    q.push_back('{sel: 0, addr: 16'h8000, data: 8'hA5});
    drain();
    read_exp(0, 16'h0001, 8'h42);
    read_exp(0, 16'h8000, 8'hA5);

    // ROM write: dropped, single wp_err pulse, count 1, contents intact.
    do_write(0, 16'h0002, 8'hFF);
    @(negedge clock);
    check("wp_err pulse", {15'd0, wp_err_a[0]}, 16'd1);
    check("wp_count one", {8'd0, wp_count_a[0]}, 16'd1);
    @(negedge clock);
    check("wp_err clear", {15'd0, wp_err_a[0]}, 16'd0);
    read_exp(0, 16'h0002, 8'h76);

    // we during the stall cycle of a new address is ignored.
    @(posedge clock); #1;
    address_a[0] = 16'h0020; out_a[0] = 8'h55; we_a[0] = 1'b1;
    @(negedge clock);
    check("we stall ready", {15'd0, ready_a[0]}, 16'd0);
    @(posedge clock); #1 we_a[0] = 1'b0;
    @(negedge clock);
    check("stall we no wp_err", {15'd0, wp_err_a[0]}, 16'd0);
    check("stall we no count", {8'd0, wp_count_a[0]}, 16'd1);

    // Many protected writes: count saturates.
    @(posedge clock); #1;
    address_a[0] = 16'h0010; out_a[0] = 8'hFF; we_a[0] = 1'b1;
    repeat (302) @(posedge clock);
    #1 we_a[0] = 1'b0;
    @(negedge clock);
    check("wp_count sat", {8'd0, wp_count_a[0]}, 16'h00FF);

    // Second instance: loader pointer wraps FFFF -> 0000.
    send_byte(1, 8'h11, 1'b0);
    send_byte(1, 8'h22, 1'b1);
    read_exp(1, 16'hFFFF, 8'h11);
    read_exp(1, 16'h0000, 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
